// File: rtl/matrix_mac_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_mac_pkg
//  Description : Shared constants, FSM state type and tile packing helper for
//                the 4x4 matrix MAC datapath and its operand loader.
//  Revision    : 1.0 - initial release
// ============================================================================
package matrix_mac_pkg;

    localparam int MATRIX_DIM         = 4;
    localparam int TILE_ELEMS         = 16;
    localparam int IDX_WIDTH          = 5;
    localparam int DEFAULT_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        PRESENT = 2'd2
    } state_t;

    // LSB position of element [r][c] in a row-major flat tile bus.
    function automatic int elem_lsb(input int r, input int c,
                                    input int dw = DEFAULT_DATA_WIDTH);
        return (r * MATRIX_DIM + c) * dw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/matrix_operand_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_operand_loader_if
//  Description : Stream-in and tile-out handshake bundle of the operand loader.
//                slave = loader side, master = surrounding logic side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface matrix_operand_loader_if #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) ();

    logic                       enable;
    logic                       clear;
    logic [DATA_WIDTH-1:0]      in_data;
    logic                       in_valid;
    logic                       in_last;
    logic                       in_ready;
    logic [16*DATA_WIDTH-1:0]   matrix_1;
    logic [16*DATA_WIDTH-1:0]   matrix_2;
    logic                       tile_valid;
    logic                       tile_ready;
    logic                       frame_err;
    logic [CNT_WIDTH-1:0]       tile_count;

    modport slave (
        input  enable, clear, in_data, in_valid, in_last, tile_ready,
        output in_ready, matrix_1, matrix_2, tile_valid, frame_err, tile_count
    );

    modport master (
        output enable, clear, in_data, in_valid, in_last, tile_ready,
        input  in_ready, matrix_1, matrix_2, tile_valid, frame_err, tile_count
    );

endinterface
`default_nettype wire

// File: rtl/matrix_operand_loader_tile_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_tile_buffer
//  Description : 16-entry element store for one 4x4 tile, single write port,
//                whole tile readable as a flat row-major bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module matrix_tile_buffer
    import matrix_mac_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  wire logic                             clock,
    input  wire logic                             reset,
    input  wire logic                             wr_en,
    input  wire logic [3:0]                       wr_idx,
    input  wire logic [DATA_WIDTH-1:0]            wr_data,
    output logic      [TILE_ELEMS*DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [TILE_ELEMS];

    // Element storage: cleared on reset, one element written per cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < TILE_ELEMS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (wr_en) begin
            r_mem[wr_idx] <= wr_data;
        end
    end

    generate
        for (genvar gr = 0; gr < MATRIX_DIM; gr++) begin : g_row
            for (genvar gc = 0; gc < MATRIX_DIM; gc++) begin : g_col
                assign rd_data[elem_lsb(gr, gc, DATA_WIDTH) +: DATA_WIDTH] =
                    r_mem[gr * MATRIX_DIM + gc];
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/matrix_operand_loader.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_operand_loader
//  Description : Collects a 32-element stream into an A tile and a B tile,
//                presents them to the MAC stage and counts delivered pairs.
//                Framing is checked against the in_last marker.
//  Revision    : 1.0 - initial release
// ============================================================================
module matrix_operand_loader
    import matrix_mac_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  wire logic                 clock,
    input  wire logic                 reset,
    matrix_operand_loader_if.slave    bus
);

    localparam logic [IDX_WIDTH-1:0] C_IDX_LAST_A  = IDX_WIDTH'(TILE_ELEMS - 1);
    localparam logic [IDX_WIDTH-1:0] C_IDX_FIRST_B = IDX_WIDTH'(TILE_ELEMS);
    localparam logic [IDX_WIDTH-1:0] C_IDX_LAST_B  = IDX_WIDTH'(2 * TILE_ELEMS - 1);

    state_t                 r_state;
    state_t                 w_state_next;
    logic [IDX_WIDTH-1:0]   r_idx;
    logic [IDX_WIDTH-1:0]   w_idx_next;
    logic                   r_tile_valid;
    logic                   w_tile_valid_next;
    logic                   r_frame_err;
    logic                   w_frame_err_next;
    logic [CNT_WIDTH-1:0]   r_tile_count;
    logic [CNT_WIDTH-1:0]   w_tile_count_next;

    logic                   w_in_ready;
    logic                   w_accept;
    logic                   w_wr_a;
    logic                   w_wr_b;
    logic [TILE_ELEMS*DATA_WIDTH-1:0] w_tile_a;
    logic [TILE_ELEMS*DATA_WIDTH-1:0] w_tile_b;

    assign w_in_ready = bus.enable && (r_state != PRESENT);
    assign w_accept   = bus.in_valid && w_in_ready;

    // State, index, status flags and delivery counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= LOAD_A;
            r_idx        <= '0;
            r_tile_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_tile_count <= '0;
        end else begin
            r_state      <= w_state_next;
            r_idx        <= w_idx_next;
            r_tile_valid <= w_tile_valid_next;
            r_frame_err  <= w_frame_err_next;
            r_tile_count <= w_tile_count_next;
        end
    end

    // Next-state logic: loading, framing check, presentation handshake; clear overrides all.
    always_comb begin
        w_state_next      = r_state;
        w_idx_next        = r_idx;
        w_tile_valid_next = r_tile_valid;
        w_frame_err_next  = 1'b0;
        w_tile_count_next = r_tile_count;
        w_wr_a            = 1'b0;
        w_wr_b            = 1'b0;

        if (bus.clear) begin
            w_state_next      = LOAD_A;
            w_idx_next        = '0;
            w_tile_valid_next = 1'b0;
        end else begin
            unique case (r_state)
                LOAD_A: begin
                    if (w_accept) begin
                        if (bus.in_last) begin
                            // Early end-of-frame: the partial tile is abandoned.
                            w_frame_err_next = 1'b1;
                            w_idx_next       = '0;
                        end else begin
                            w_wr_a = 1'b1;
                            if (r_idx == C_IDX_LAST_A) begin
                                w_state_next = LOAD_B;
                                w_idx_next   = C_IDX_FIRST_B;
                            end else begin
                                w_idx_next = r_idx + IDX_WIDTH'(1);
                            end
                        end
                    end
                end
                LOAD_B: begin
                    if (w_accept) begin
                        if (r_idx == C_IDX_LAST_B) begin
                            w_idx_next = '0;
                            if (bus.in_last) begin
                                w_wr_b            = 1'b1;
                                w_state_next      = PRESENT;
                                w_tile_valid_next = 1'b1;
                            end else begin
                                // Missing end-of-frame marker: the pair is never presented.
                                w_frame_err_next = 1'b1;
                                w_state_next     = LOAD_A;
                            end
                        end else if (bus.in_last) begin
                            w_frame_err_next = 1'b1;
                            w_state_next     = LOAD_A;
                            w_idx_next       = '0;
                        end else begin
                            w_wr_b     = 1'b1;
                            w_idx_next = r_idx + IDX_WIDTH'(1);
                        end
                    end
                end
                PRESENT: begin
                    if (r_tile_valid && bus.tile_ready) begin
                        w_tile_valid_next = 1'b0;
                        w_tile_count_next = r_tile_count + CNT_WIDTH'(1);
                        w_state_next      = LOAD_A;
                        w_idx_next        = '0;
                    end
                end
                default: begin
                    w_state_next      = LOAD_A;
                    w_idx_next        = '0;
                    w_tile_valid_next = 1'b0;
                end
            endcase
        end
    end

    matrix_tile_buffer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf_a (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (w_wr_a),
        .wr_idx  (r_idx[3:0]),
        .wr_data (bus.in_data),
        .rd_data (w_tile_a)
    );

    matrix_tile_buffer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf_b (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (w_wr_b),
        .wr_idx  (r_idx[3:0]),
        .wr_data (bus.in_data),
        .rd_data (w_tile_b)
    );

    assign bus.in_ready   = w_in_ready;
    assign bus.matrix_1   = w_tile_a;
    assign bus.matrix_2   = w_tile_b;
    assign bus.tile_valid = r_tile_valid;
    assign bus.frame_err  = r_frame_err;
    assign bus.tile_count = r_tile_count;

endmodule
`default_nettype wire

// File: tb/tb_matrix_operand_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_matrix_operand_loader
//  Description : Directed bench for matrix_operand_loader. Expected tile pairs
//                and framing errors are queued by the stimulus and retired by
//                a monitor whenever the loader hands over a tile or flags an
//                error. The counter is built 4 bits wide here so that its
//                wrap from all-ones to zero is reached in a short run.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_operand_loader;

    localparam int DW = 8;
    localparam int CW = 4;

    typedef struct packed {
        logic [16*DW-1:0] m1;
        logic [16*DW-1:0] m2;
    } tile_t;

    logic clock;
    logic reset;

    matrix_operand_loader_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

    matrix_operand_loader #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    tile_t  exp_q[$];
    int     exp_ferr;
    int     n_vec;
    int     n_err;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [16*DW-1:0] exp_tile(input int base);
        logic [16*DW-1:0] v;
        v = '0;
        for (int i = 0; i < 16; i++) begin
            v[i*DW +: DW] = DW'(base + i);
        end
        return v;
    endfunction

    // One element; returns at the falling edge after the accepting clock edge.
    task automatic send_elem(input int d, input bit last, input bit rnd);
        bit acc;
        acc = 1'b0;
        if (rnd) begin
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = DW'(d);
        bus.in_last  = last;
        for (int g = 0; g < 200 && !acc; g++) begin
            if (rnd) bus.enable = ($urandom_range(0, 3) != 0);
            #1;
            acc = bus.in_ready;
            @(posedge clock);
            @(negedge clock);
        end
        if (!acc) chk("accept_timeout", 0, 1);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.enable   = 1'b1;
    endtask

    task automatic send_frame(input int base, input int n, input int last_at,
                              input bit rnd, input bit push);
        tile_t t;
        if (push) begin
            t.m1 = exp_tile(base);
            t.m2 = exp_tile(base + 16);
            exp_q.push_back(t);
        end
        for (int i = 0; i < n; i++) begin
            send_elem(base + i, (i + 1) == last_at, rnd);
        end
    endtask

    // Waits for the tile handshake; returns at the falling edge after it.
    task automatic wait_delivery();
        bit done;
        done = 1'b0;
        for (int g = 0; g < 100 && !done; g++) begin
            if (bus.tile_valid && bus.tile_ready) begin
                @(posedge clock);
                done = 1'b1;
            end
            @(negedge clock);
        end
        if (!done) chk("delivery_timeout", 0, 1);
    endtask

    initial begin
        tile_t t;
        logic [16*DW-1:0] e1;
        logic [16*DW-1:0] e2;
        logic [DW-1:0]    el;
        n_vec = 0;
        n_err = 0;
        exp_ferr = 0;
        reset = 1'b1;
        bus.enable = 1'b1;
        bus.clear = 1'b0;
        bus.in_data = '0;
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
        bus.tile_ready = 1'b0;

        fork
            // Monitor: retires queued expectations as the loader produces them.
            forever begin
                @(negedge clock);
                #3;
                if (!reset && !bus.clear && bus.tile_valid && bus.tile_ready) begin
                    chk("tile_expected", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        t = exp_q.pop_front();
                        chk("matrix_1", bus.matrix_1, t.m1);
                        chk("matrix_2", bus.matrix_2, t.m2);
                    end
                end
                if (!reset && bus.frame_err) begin
                    chk("frame_err_expected", 32'(exp_ferr > 0), 1);
                    if (exp_ferr > 0) exp_ferr--;
                end
            end
        join_none

        repeat (2) @(negedge clock);
        chk("rst_tile_valid", bus.tile_valid, 0);
        chk("rst_frame_err",  bus.frame_err, 0);
        chk("rst_tile_count", bus.tile_count, 0);
        chk("rst_matrix_1",   bus.matrix_1, 0);
        chk("rst_matrix_2",   bus.matrix_2, 0);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_in_ready", bus.in_ready, 1);

        // 1: clean frame 1..32 delivered straight away.
        bus.tile_ready = 1'b1;
        send_frame(1, 32, 32, 1'b0, 1'b1);
        chk("t1_tile_valid", bus.tile_valid, 1);
        el = bus.matrix_1[0 +: DW];    chk("t1_a00", el, 8'd1);
        el = bus.matrix_1[15*DW +: DW]; chk("t1_a33", el, 8'd16);
        el = bus.matrix_2[0 +: DW];    chk("t1_b00", el, 8'd17);
        el = bus.matrix_2[15*DW +: DW]; chk("t1_b33", el, 8'd32);
        wait_delivery();
        chk("t1_count", bus.tile_count, 1);
        chk("t1_valid_low", bus.tile_valid, 0);
        chk("t1_in_ready", bus.in_ready, 1);

        // 2: tile held for 10 cycles with tile_ready low while in_valid is offered.
        bus.tile_ready = 1'b0;
        send_frame(100, 32, 32, 1'b0, 1'b1);
        e1 = exp_tile(100);
        e2 = exp_tile(116);
        for (int k = 0; k < 10; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = DW'(8'hE0 + k);
            #1;
            chk("t2_in_ready", bus.in_ready, 0);
            chk("t2_valid", bus.tile_valid, 1);
            chk("t2_m1_hold", bus.matrix_1, e1);
            chk("t2_m2_hold", bus.matrix_2, e2);
            @(negedge clock);
        end
        bus.in_valid = 1'b0;
        bus.tile_ready = 1'b1;
        wait_delivery();
        chk("t2_count", bus.tile_count, 2);
        chk("t2_in_ready", bus.in_ready, 1);

        // 3: in_last on element 20, then a clean frame.
        exp_ferr++;
        send_frame(40, 20, 20, 1'b0, 1'b0);
        chk("t3_frame_err", bus.frame_err, 1);
        chk("t3_valid", bus.tile_valid, 0);
        @(negedge clock);
        chk("t3_frame_err_pulse", bus.frame_err, 0);
        send_frame(50, 32, 32, 1'b0, 1'b1);
        wait_delivery();
        chk("t3_count", bus.tile_count, 3);

        // 4: 32 elements without in_last.
        exp_ferr++;
        send_frame(80, 32, 0, 1'b0, 1'b0);
        chk("t4_frame_err", bus.frame_err, 1);
        chk("t4_valid", bus.tile_valid, 0);
        @(negedge clock);
        chk("t4_valid_later", bus.tile_valid, 0);
        chk("t4_count", bus.tile_count, 3);

        // 5a: clear at element 10, then a clean frame must start at index 0.
        send_frame(200, 9, 0, 1'b0, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = DW'(209);
        bus.clear    = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.clear    = 1'b0;
        bus.in_valid = 1'b0;
        chk("t5_in_ready", bus.in_ready, 1);
        send_frame(10, 32, 32, 1'b0, 1'b1);
        wait_delivery();
        chk("t5_count", bus.tile_count, 4);

        // 5b: clear during PRESENT together with tile_ready drops the pair.
        bus.tile_ready = 1'b0;
        send_frame(70, 32, 32, 1'b0, 1'b0);
        chk("t5_present", bus.tile_valid, 1);
        bus.clear = 1'b1;
        bus.tile_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.clear = 1'b0;
        chk("t5_clear_valid", bus.tile_valid, 0);
        chk("t5_clear_count", bus.tile_count, 4);
        chk("t5_clear_in_ready", bus.in_ready, 1);

        // 6: gaps and enable toggling, then reset mid-LOAD_B.
        send_frame(150, 32, 32, 1'b1, 1'b1);
        wait_delivery();
        chk("t6_count", bus.tile_count, 5);
        send_frame(90, 20, 0, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_rst_valid", bus.tile_valid, 0);
        chk("t6_rst_count", bus.tile_count, 0);
        chk("t6_rst_m1", bus.matrix_1, 0);
        chk("t6_rst_m2", bus.matrix_2, 0);
        chk("t6_rst_ferr", bus.frame_err, 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Counter wrap: 15 deliveries reach all-ones, the 16th returns to 0.
        for (int k = 0; k < 16; k++) begin
            send_frame(k * 3 + 1, 32, 32, 1'b0, 1'b1);
            wait_delivery();
            if (k == 14) chk("wrap_max", bus.tile_count, 15);
            if (k == 15) chk("wrap_zero", bus.tile_count, 0);
        end

        repeat (3) @(negedge clock);
        chk("tiles_outstanding", 32'(exp_q.size()), 0);
        chk("ferr_outstanding", 32'(exp_ferr), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
